load_store_unit: RTL and testbench
==================================

# load_store_unit

Sits between the core's execute stage and the word-only data memory, converting RV32I loads and stores (LB, LH, LW, LBU, LHU, SB, SH, SW) into word-aligned memory accesses. Loads are extracted and sign- or zero-extended from the addressed word in the same cycle. Sub-word stores run a two-cycle read-merge-write sequence and stall the core for one cycle. Word stores pass straight through.

## Interface
Parameters:
- ADDR_W, 32, width of the core and memory address buses.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE.
- cpu_memread  in  1  load request from the core.
- cpu_memwrite  in  1  store request from the core.
- cpu_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- cpu_address  in  ADDR_W  byte address.
- cpu_write_data  in  32  store data, LSB-justified.
- cpu_read_data  out  32  extended load result; 0 when no load completes.
- stall  out  1  core must hold its request and not advance.
- misaligned  out  1  access violates natural alignment; access suppressed.
- mem_memread  out  1  to data memory.
- mem_memwrite  out  1  to data memory.
- mem_address  out  ADDR_W  {cpu_address[ADDR_W-1:2], 2'b00}.
- mem_write_data  out  32  full word to write.
- mem_read_data  in  32  combinational read data from memory.

## Operation
- States: IDLE, WRITE. Reset value is IDLE; every output is 0 in reset except mem_address, which follows cpu_address.
- Legal funct3: stores accept 000, 001, 010; loads accept all five. Any other code performs no access, all outputs 0.
- Alignment: H and HU need address[0]=0; W needs address[1:0]=00; B is always aligned.
- Load, IDLE: mem_memread=1. The word is shifted right by 8*address[1:0], then bits [7:0] or [15:0] are sign- or zero-extended per funct3. The result drives cpu_read_data combinationally, with stall=0.
- SW, IDLE: mem_memwrite=1, mem_write_data=cpu_write_data, stall=0. It completes in one cycle.
- SB/SH, IDLE: mem_memread=1 and stall=1.
  - The merged word is latched: mem_read_data with byte lane address[1:0] (SB) or halfword lane address[1] (SH) replaced by cpu_write_data[7:0] or [15:0].
  - The word address is latched, and the state goes to WRITE.
- WRITE:
  - mem_memwrite=1, mem_address=latched address, mem_write_data=latched word, stall=0.
  - Core inputs are ignored. The state returns to IDLE at the next edge.
- If cpu_memread and cpu_memwrite are both high, the store wins and cpu_read_data=0.
- Reset asserted in WRITE: the state drops to IDLE asynchronously and mem_memwrite deasserts immediately, so no partial write occurs.

## Timing
- Load latency 0: the result is valid in the request cycle.
- SW: 1 cycle, written at the edge ending cycle N.
- SB/SH: 2 cycles. Memory is read in cycle N (stall=1) and written at the edge ending cycle N+1 (stall=0). The core advances after N+1.
- A back-to-back sub-word store immediately after WRITE starts a new sequence in the following IDLE cycle. Throughput is one sub-word store per 2 cycles.
- misaligned is combinational, asserted in the request cycle only, and never causes a stall.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - A misaligned access asserts misaligned.
  - It forces mem_memread=0, mem_memwrite=0 and cpu_read_data=0, and does not enter WRITE.
- LSU_MISALIGN_TRAP_EN undefined:
  - misaligned is tied 0.
  - Misaligned addresses are truncated down to natural alignment (address[0] cleared for H; address[1:0] cleared for W) and the access proceeds.

## Test plan
- Reset: assert reset mid-WRITE -> mem_memwrite falls within the same cycle, and memory word 0x10 is unchanged. After release, the state is IDLE and stall=0.
- LB/LBU: memory word 0x10 = 0x80FF7F01; LB from 0x13 -> 0xFFFFFF80; LBU from 0x13 -> 0x00000080; LB from 0x11 -> 0x0000007F. All complete with stall=0.
- LH/LHU: same word; LH from 0x12 -> 0xFFFF80FF; LHU from 0x12 -> 0x000080FF.
- SB: word 0x20 = 0x11223344; SB 0xAB to 0x21 -> stall=1 for one cycle, then memory holds 0x1122AB44. Repeat with SH 0xBEEF to 0x22 -> 0xBEEFAB44.
- SW: SW 0xDEADBEEF to 0x24 -> written in one cycle, stall never high. A following LW from 0x24 returns 0xDEADBEEF.
- Misalignment: LW from 0x26 and SH to 0x21.
  - With LSU_MISALIGN_TRAP_EN: misaligned=1, no memread/memwrite, memory unchanged.
  - Without it: LW returns word 0x24, SH writes the lower halfword of word 0x20.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: converts RV32I loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW)
// into word-aligned accesses on a word-only data memory.
// Loads complete combinationally in the request cycle; SW passes straight
// through; SB/SH run a read-merge-write sequence (IDLE -> WRITE) that stalls
// the core for one cycle.
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   -> misaligned accesses assert 'misaligned' and are suppressed
//   undefined -> misaligned is tied 0 and addresses truncate to natural alignment
module load_store_unit #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_memread,
   input  logic              cpu_memwrite,
   input  logic [2:0]        cpu_funct3,
   input  logic [ADDR_W-1:0] cpu_address,
   input  logic [31:0]       cpu_write_data,
   output logic [31:0]       cpu_read_data,
   output logic              stall,
   output logic              misaligned,
   output logic              mem_memread,
   output logic              mem_memwrite,
   output logic [ADDR_W-1:0] mem_address,
   output logic [31:0]       mem_write_data,
   input  logic [31:0]       mem_read_data
);

   typedef enum logic {IDLE, WRITE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [31:0]       word_q,  word_d;

   logic [ADDR_W-1:0] word_addr;
   logic              store_ok, load_ok, trap;
   logic [1:0]        off;
   logic [31:0]       shifted, load_ext, merged;

   assign word_addr = {cpu_address[ADDR_W-1:2], 2'b00};

   // Legal-request decode; a store request takes priority over a load.
   assign store_ok = cpu_memwrite &&
                     (cpu_funct3 == 3'b000 || cpu_funct3 == 3'b001 || cpu_funct3 == 3'b010);
   assign load_ok  = !cpu_memwrite && cpu_memread &&
                     (cpu_funct3 == 3'b000 || cpu_funct3 == 3'b001 || cpu_funct3 == 3'b010 ||
                      cpu_funct3 == 3'b100 || cpu_funct3 == 3'b101);

`ifdef LSU_MISALIGN_TRAP_EN
   assign trap = (cpu_funct3[1:0] == 2'b01 && cpu_address[0]) ||
                 (cpu_funct3[1:0] == 2'b10 && cpu_address[1:0] != 2'b00);
`else
   assign trap = 1'b0;
`endif

   // Byte offset inside the word, truncated down to the natural alignment of the size.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      off = 2'b00;
      case (cpu_funct3[1:0])
         2'b00:   off = cpu_address[1:0];
         2'b01:   off = {cpu_address[1], 1'b0};
         default: off = 2'b00;
      endcase
   end

   // Load extraction and sign/zero extension from the addressed word.
   always_comb begin
      shifted  = mem_read_data >> {off, 3'b000};
      load_ext = 32'h0;
      case (cpu_funct3)
         3'b000:  load_ext = {{24{shifted[7]}},  shifted[7:0]};
         3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
         3'b010:  load_ext = shifted;
         3'b100:  load_ext = {24'h0, shifted[7:0]};
         3'b101:  load_ext = {16'h0, shifted[15:0]};
         default: load_ext = 32'h0;
      endcase
   end

   // Sub-word store merge: replace the addressed byte/halfword lane of the read word.
   always_comb begin
      merged = mem_read_data;
      if (cpu_funct3[0] == 1'b0)
         merged[{off, 3'b000} +: 8] = cpu_write_data[7:0];
      else
         merged[{off[1], 4'b0000} +: 16] = cpu_write_data[15:0];
   end

   // Next-state and output decode; reset forces every output low except mem_address.
   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      word_d         = word_q;
      cpu_read_data  = 32'h0;
      stall          = 1'b0;
      misaligned     = 1'b0;
      mem_memread    = 1'b0;
      mem_memwrite   = 1'b0;
      mem_address    = word_addr;
      mem_write_data = 32'h0;
      if (reset) begin
         state_d = IDLE;
      end else if (state_q == WRITE) begin
         mem_memwrite   = 1'b1;
         mem_address    = addr_q;
         mem_write_data = word_q;
         state_d        = IDLE;
      end else if (store_ok) begin
         if (trap) begin
            misaligned = 1'b1;
         end else if (cpu_funct3[1:0] == 2'b10) begin
            mem_memwrite   = 1'b1;
            mem_write_data = cpu_write_data;
         end else begin
            mem_memread = 1'b1;
            stall       = 1'b1;
            addr_d      = word_addr;
            word_d      = merged;
            state_d     = WRITE;
         end
      end else if (load_ok) begin
         if (trap) begin
            misaligned = 1'b1;
         end else begin
            mem_memread   = 1'b1;
            cpu_read_data = load_ext;
         end
      end
   end

   // State, latched word address and merged word; async reset drops WRITE at once.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         word_q  <= word_d;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a small word memory.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_memread, cpu_memwrite;
   logic [2:0]  cpu_funct3;
   logic [31:0] cpu_address, cpu_write_data;
   logic [31:0] cpu_read_data;
   logic        stall, misaligned, mem_memread, mem_memwrite;
   logic [31:0] mem_address, mem_write_data, mem_read_data;

   logic [31:0] mem [64];
   int n_cmp = 0;
   int n_err = 0;

   load_store_unit #(.ADDR_W(32)) dut (
      .clk(clk), .reset(reset),
      .cpu_memread(cpu_memread), .cpu_memwrite(cpu_memwrite),
      .cpu_funct3(cpu_funct3), .cpu_address(cpu_address),
      .cpu_write_data(cpu_write_data), .cpu_read_data(cpu_read_data),
      .stall(stall), .misaligned(misaligned),
      .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
      .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_read_data(mem_read_data)
   );

   always #5 clk = ~clk;

   // Word memory: combinational read, write on rising edge.
   assign mem_read_data = mem[mem_address[7:2]];
   always @(posedge clk) if (mem_memwrite) mem[mem_address[7:2]] <= mem_write_data;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Apply a request just after the falling edge, then let combinational outputs settle.
   task automatic req(input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd);
      @(negedge clk);
      cpu_memread = rd; cpu_memwrite = wr; cpu_funct3 = f3;
      cpu_address = addr; cpu_write_data = wd;
      #2;
   endtask

   task automatic idle();
      req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[32'h10 >> 2] = 32'h80FF7F01;
      mem[32'h20 >> 2] = 32'h11223344;

      // Reset: outputs low even with a load request present.
      reset = 1'b1;
      cpu_memread = 1'b1; cpu_memwrite = 1'b0; cpu_funct3 = 3'b010;
      cpu_address = 32'h13; cpu_write_data = 32'h0;
      #2;
      check("rst_memread", {31'h0, mem_memread}, 32'h0);
      check("rst_memwrite", {31'h0, mem_memwrite}, 32'h0);
      check("rst_stall", {31'h0, stall}, 32'h0);
      check("rst_rdata", cpu_read_data, 32'h0);
      check("rst_addr", mem_address, 32'h10);
      @(negedge clk); reset = 1'b0;
      idle();

      // Byte loads
      req(1'b1, 1'b0, 3'b000, 32'h13, 32'h0);
      check("lb_13", cpu_read_data, 32'hFFFFFF80);
      check("lb_13_stall", {31'h0, stall}, 32'h0);
      check("lb_13_memread", {31'h0, mem_memread}, 32'h1);
      check("lb_13_addr", mem_address, 32'h10);
      req(1'b1, 1'b0, 3'b100, 32'h13, 32'h0);
      check("lbu_13", cpu_read_data, 32'h00000080);
      req(1'b1, 1'b0, 3'b000, 32'h11, 32'h0);
      check("lb_11", cpu_read_data, 32'h0000007F);
      check("lb_11_stall", {31'h0, stall}, 32'h0);

      // Halfword loads
      req(1'b1, 1'b0, 3'b001, 32'h12, 32'h0);
      check("lh_12", cpu_read_data, 32'hFFFF80FF);
      req(1'b1, 1'b0, 3'b101, 32'h12, 32'h0);
      check("lhu_12", cpu_read_data, 32'h000080FF);

      // SB 0xAB -> 0x21: read/stall cycle, then write cycle
      req(1'b0, 1'b1, 3'b000, 32'h21, 32'h000000AB);
      check("sb_stall", {31'h0, stall}, 32'h1);
      check("sb_memread", {31'h0, mem_memread}, 32'h1);
      check("sb_nowrite", {31'h0, mem_memwrite}, 32'h0);
      req(1'b0, 1'b1, 3'b000, 32'h21, 32'h000000AB);
      check("sb_w_stall", {31'h0, stall}, 32'h0);
      check("sb_w_memwrite", {31'h0, mem_memwrite}, 32'h1);
      check("sb_w_addr", mem_address, 32'h20);
      check("sb_w_data", mem_write_data, 32'h1122AB44);
      idle();
      check("sb_mem", mem[8], 32'h1122AB44);

      // SH 0xBEEF -> 0x22
      req(1'b0, 1'b1, 3'b001, 32'h22, 32'h0000BEEF);
      check("sh_stall", {31'h0, stall}, 32'h1);
      req(1'b0, 1'b1, 3'b001, 32'h22, 32'h0000BEEF);
      check("sh_w_stall", {31'h0, stall}, 32'h0);
      idle();
      check("sh_mem", mem[8], 32'hBEEFAB44);

      // SW passes straight through, then LW reads it back
      req(1'b0, 1'b1, 3'b010, 32'h24, 32'hDEADBEEF);
      check("sw_stall", {31'h0, stall}, 32'h0);
      check("sw_memwrite", {31'h0, mem_memwrite}, 32'h1);
      check("sw_data", mem_write_data, 32'hDEADBEEF);
      req(1'b1, 1'b0, 3'b010, 32'h24, 32'h0);
      check("lw_24", cpu_read_data, 32'hDEADBEEF);
      check("lw_24_stall", {31'h0, stall}, 32'h0);

      // Load and store together: store wins, no load data
      req(1'b1, 1'b1, 3'b010, 32'h28, 32'h12345678);
      check("both_rdata", cpu_read_data, 32'h0);
      check("both_memwrite", {31'h0, mem_memwrite}, 32'h1);
      check("both_memread", {31'h0, mem_memread}, 32'h0);

      // Illegal funct3: no access
      req(1'b1, 1'b0, 3'b011, 32'h24, 32'h0);
      check("ill_ld_memread", {31'h0, mem_memread}, 32'h0);
      check("ill_ld_rdata", cpu_read_data, 32'h0);
      req(1'b0, 1'b1, 3'b100, 32'h24, 32'h0);
      check("ill_st_memwrite", {31'h0, mem_memwrite}, 32'h0);
      check("ill_st_stall", {31'h0, stall}, 32'h0);
      check("ill_st_memread", {31'h0, mem_memread}, 32'h0);

      // Back-to-back SB: 0x11 -> 0x24 then 0x22 -> 0x25
      req(1'b0, 1'b1, 3'b000, 32'h24, 32'h11);
      check("b2b_1_stall", {31'h0, stall}, 32'h1);
      req(1'b0, 1'b1, 3'b000, 32'h24, 32'h11);
      check("b2b_1_write", {31'h0, mem_memwrite}, 32'h1);
      req(1'b0, 1'b1, 3'b000, 32'h25, 32'h22);
      check("b2b_2_stall", {31'h0, stall}, 32'h1);
      check("b2b_2_mid", mem[9], 32'hDEADBE11);
      req(1'b0, 1'b1, 3'b000, 32'h25, 32'h22);
      check("b2b_2_data", mem_write_data, 32'hDEAD2211);
      idle();
      check("b2b_mem", mem[9], 32'hDEAD2211);

      // Misaligned LW 0x26 and SH 0x21
`ifdef LSU_MISALIGN_TRAP_EN
      req(1'b1, 1'b0, 3'b010, 32'h26, 32'h0);
      check("mis_lw_flag", {31'h0, misaligned}, 32'h1);
      check("mis_lw_memread", {31'h0, mem_memread}, 32'h0);
      check("mis_lw_rdata", cpu_read_data, 32'h0);
      req(1'b0, 1'b1, 3'b001, 32'h21, 32'h5555);
      check("mis_sh_flag", {31'h0, misaligned}, 32'h1);
      check("mis_sh_stall", {31'h0, stall}, 32'h0);
      check("mis_sh_memread", {31'h0, mem_memread}, 32'h0);
      check("mis_sh_memwrite", {31'h0, mem_memwrite}, 32'h0);
      idle();
      check("mis_sh_flag_clr", {31'h0, misaligned}, 32'h0);
      check("mis_sh_mem", mem[8], 32'hBEEFAB44);
`else
      req(1'b1, 1'b0, 3'b010, 32'h26, 32'h0);
      check("mis_lw_flag", {31'h0, misaligned}, 32'h0);
      check("mis_lw_rdata", cpu_read_data, 32'hDEAD2211);
      req(1'b0, 1'b1, 3'b001, 32'h21, 32'h5555);
      check("mis_sh_flag", {31'h0, misaligned}, 32'h0);
      check("mis_sh_stall", {31'h0, stall}, 32'h1);
      req(1'b0, 1'b1, 3'b001, 32'h21, 32'h5555);
      check("mis_sh_data", mem_write_data, 32'hBEEF5555);
      idle();
      check("mis_sh_mem", mem[8], 32'hBEEF5555);
`endif

      // Reset asserted mid-WRITE: the write must drop immediately
      req(1'b0, 1'b1, 3'b000, 32'h10, 32'h0);
      check("rw_stall", {31'h0, stall}, 32'h1);
      req(1'b0, 1'b1, 3'b000, 32'h10, 32'h0);
      check("rw_in_write", {31'h0, mem_memwrite}, 32'h1);
      reset = 1'b1;
      #1;
      check("rw_memwrite_drop", {31'h0, mem_memwrite}, 32'h0);
      check("rw_stall_drop", {31'h0, stall}, 32'h0);
      @(negedge clk);
      cpu_memwrite = 1'b0;
      reset = 1'b0;
      #2;
      check("rw_mem", mem[4], 32'h80FF7F01);
      check("rw_idle_stall", {31'h0, stall}, 32'h0);
      check("rw_idle_memwrite", {31'h0, mem_memwrite}, 32'h0);
      req(1'b1, 1'b0, 3'b100, 32'h10, 32'h0);
      check("rw_lbu_10", cpu_read_data, 32'h00000001);
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
